// File: rtl/shifter.sv
// shifter: registered 32-bit SLL/SRL/SRA barrel shifter; type=11 rotates right when SHIFTER_ROR_EN is defined, else passes a through
module shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op_type,
  output logic [WIDTH-1:0]   r,
  output logic               out_valid
);
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    for (int j = 0; j < WIDTH; j++) rev[j] = v[WIDTH-1-j];
  endfunction
  logic [WIDTH-1:0] stg [0:SHAMT_W];
  logic             sign;
  logic [WIDTH-1:0] res;
  assign sign   = (op_type == 2'b10) & a[WIDTH-1];
  assign stg[0] = (op_type == 2'b00) ? rev(a) : a;
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    logic [S-1:0] fill;
`ifdef SHIFTER_ROR_EN
    assign fill = (op_type == 2'b11) ? stg[i][S-1:0] : {S{sign}};
`else
    assign fill = {S{sign}};
`endif
    assign stg[i+1] = shamt[i] ? {fill, stg[i][WIDTH-1:S]} : stg[i];
  end
`ifdef SHIFTER_ROR_EN
  assign res = (op_type == 2'b00) ? rev(stg[SHAMT_W]) : stg[SHAMT_W];
`else
  assign res = (op_type == 2'b00) ? rev(stg[SHAMT_W]) : (op_type == 2'b11) ? a : stg[SHAMT_W];
`endif
  // r only loads on accepted inputs, so idle-cycle X on shamt/op_type never reaches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) r <= res;
    end
  end
endmodule

// File: tb/tb_shifter.sv
// tb_shifter: directed and random checks of shifter against an arithmetic reference model
module tb_shifter;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  t;
  logic [31:0] r;
  logic        out_valid;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_r;
  shifter dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .shamt(shamt),
               .op_type(t), .r(r), .out_valid(out_valid));
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [31:0] x, input int s, input logic [1:0] k);
    case (k)
      2'b00: return x << s;
      2'b01: return x >> s;
      2'b10: return 32'($signed(x) >>> s);
`ifdef SHIFTER_ROR_EN
      default: return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
`else
      default: return x;
`endif
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic go(input string tag, input logic [31:0] x, input logic [4:0] s, input logic [1:0] k);
    in_valid = 1; a = x; shamt = s; t = k;
    exp_r = model(x, int'(s), k);
    @(posedge clk); #1;
    check({tag, "_r"}, r, exp_r);
    check({tag, "_v"}, {31'd0, out_valid}, 32'd1);
  endtask
  task automatic idle(input string tag);
    in_valid = 0; a = $urandom; shamt = 'x; t = 'x;
    @(posedge clk); #1;
    check({tag, "_r"}, r, exp_r);
    check({tag, "_v"}, {31'd0, out_valid}, 32'd0);
  endtask
  initial begin
    rst_n = 0; in_valid = 1; a = 32'hFFFF_FFFF; shamt = 5'd1; t = 2'b01; exp_r = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r", r, 32'd0);
    check("rst_v", {31'd0, out_valid}, 32'd0);
    in_valid = 0; rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_v", {31'd0, out_valid}, 32'd0);
    check("post_rst_r", r, 32'd0);
    check("sll_f4", model(32'h0000_000F, 4, 2'b00), 32'h0000_00F0);
    go("sll_f4", 32'h0000_000F, 5'd4, 2'b00);
    go("sll_ff8", 32'h0000_00FF, 5'd8, 2'b00);
    check("sll_ff8_const", r, 32'h0000_FF00);
    go("srl_4", 32'hF000_0000, 5'd4, 2'b01);
    check("srl_4_const", r, 32'h0F00_0000);
    go("srl_8", 32'h8000_0000, 5'd8, 2'b01);
    go("srl_31", 32'h8000_0000, 5'd31, 2'b01);
    check("srl_31_const", r, 32'h0000_0001);
    go("sra_4", 32'hF000_0000, 5'd4, 2'b10);
    check("sra_4_const", r, 32'hFF00_0000);
    go("sra_8", 32'h8000_0000, 5'd8, 2'b10);
    check("sra_8_const", r, 32'hFF80_0000);
    go("sra_pos", 32'h7000_0000, 5'd4, 2'b10);
    check("sra_pos_const", r, 32'h0700_0000);
    go("sra_31", 32'h8000_1234, 5'd31, 2'b10);
    check("sra_31_const", r, 32'hFFFF_FFFF);
    go("sll_31", 32'h0000_0003, 5'd31, 2'b00);
    check("sll_31_const", r, 32'h8000_0000);
    go("z_sll", 32'h1234_5678, 5'd0, 2'b00);
    check("z_sll_const", r, 32'h1234_5678);
    go("z_srl", 32'h1234_5678, 5'd0, 2'b01);
    check("z_srl_const", r, 32'h1234_5678);
    go("z_sra", 32'h1234_5678, 5'd0, 2'b10);
    check("z_sra_const", r, 32'h1234_5678);
    go("t11", 32'hA5A5_A5A5, 5'd4, 2'b11);
`ifdef SHIFTER_ROR_EN
    check("t11_const", r, 32'h5A5A_5A5A);
`else
    check("t11_const", r, 32'hA5A5_A5A5);
`endif
    go("t11_z", 32'hDEAD_BEEF, 5'd0, 2'b11);
    idle("hold1");
    idle("hold2");
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3, 0) != 0) go("rnd", $urandom, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)));
      else idle("rnd_idle");
    end
    in_valid = 1; a = 32'h1111_1111; shamt = 5'd3; t = 2'b00;
    #2 rst_n = 0;
    #1;
    check("midrst_r", r, 32'd0);
    check("midrst_v", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 0; rst_n = 1; exp_r = 0;
    idle("after_rst");
    go("restart", 32'h0000_0001, 5'd5, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
